paddle_ctrl: RTL
================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter HOLD_FRAMES, default 8, number of frames up/down stays asserted after one drum hit.
REQ-002 Parameter SPEED_MIN, default 2, puck speed in pixels/frame at game start.
REQ-003 Parameter SPEED_MAX, default 12, speed ceiling, at most 15.
REQ-004 Parameter RAMP_FRAMES, default 600, number of PLAY frames per +1 speed step.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 vclock  in  1  65 MHz pixel clock; all state is on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 vsync  in  1  active-low frame sync from the timing generator; a frame boundary is its 1->0 transition.
REQ-009 hit_up, hit_down  in  1 each  single-cycle drum-hit pulses.
REQ-010 hit_start  in  1  single-cycle start/pause drum pulse.
REQ-011 game_over  in  1  single-cycle pulse that returns the game to IDLE.
REQ-012 up, down  out  1 each  paddle move commands for the pong ball stage.
REQ-013 pspeed  out  4  puck speed in pixels/frame.
REQ-014 enabled  out  1  high while the game is in PLAY.
REQ-015 frame_tick  out  1  one-cycle pulse per frame boundary.

Function
REQ-016 Detect frame boundaries synchronously: register vsync once; frame_tick=1 for exactly one cycle when the registered value is 1 and the current vsync is 0.
REQ-017 Outputs up, down, pspeed and enabled SHALL change only on the clock edge where frame_tick=1, so they stay stable for a whole frame.
REQ-018 Latch each pulse (hit_up, hit_down, hit_start, game_over) into its own pending flag; consume and clear the flags on the frame_tick edge.
REQ-019 A pulse arriving in the same cycle as frame_tick SHALL be held for the following tick and SHALL not be lost.
REQ-020 At a tick with only pending_up set: up=1, down=0, hold=HOLD_FRAMES.
REQ-021 At a tick with only pending_down set: down=1, up=0, hold=HOLD_FRAMES.
REQ-022 At a tick with both pending_up and pending_down set: up=0, down=0, hold=0.
REQ-023 At a tick with no new hit: if hold>1, decrement hold; if hold==1, set hold=0 and up=down=0.
REQ-024 As a result of REQ-020..023, a single hit asserts its output for exactly HOLD_FRAMES frames; a retrigger reloads hold.
REQ-025 up and down SHALL never both be 1.
REQ-026 Paddle commands SHALL operate in every game state.
REQ-027 Game state machine has three states: IDLE, PLAY, PAUSE; enabled=1 only in PLAY.
REQ-028 State transitions occur at a tick: IDLE -> PLAY on pending_start; PLAY -> PAUSE on pending_start; PAUSE -> PLAY on pending_start.
REQ-029 pending_game_over at a tick SHALL force IDLE from any state and takes priority over pending_start.
REQ-030 In IDLE: pspeed=SPEED_MIN and ramp counter=0.
REQ-031 In PLAY, each tick increments the ramp counter.
REQ-032 When the ramp counter reaches RAMP_FRAMES-1, it returns to 0 and pspeed increments, saturating at SPEED_MAX.
REQ-033 In PAUSE, the ramp counter and pspeed SHALL freeze.
REQ-034 The ramp counter SHALL be at least 16 bits wide.
REQ-035 pspeed arithmetic is unsigned 4-bit and SHALL never wrap.

Reset
REQ-036 When reset_n=0, asynchronously: up=0, down=0, pspeed=SPEED_MIN, enabled=0, frame_tick=0, state=IDLE, hold=0, ramp counter=0, all pending flags=0, and the vsync register=1.
REQ-037 Reset asserted mid-hold or mid-PLAY SHALL discard all pending flags.
REQ-038 After reset release, the first frame_tick SHALL require a genuine 1->0 vsync edge.

Verification
REQ-039 hit_up pulse mid-frame, HOLD_FRAMES=8 -> up=1 from the next tick for exactly 8 ticks, then 0; down=0 throughout.
REQ-040 hit_up and hit_down in the same frame while up is held -> at the next tick up=0, down=0.
REQ-041 hit_up in the same cycle as frame_tick -> no change at that tick; up=1 at the following tick.
REQ-042 hit_start, then RAMP_FRAMES=4 over 50 ticks -> enabled=1; pspeed 2->3 after 4 PLAY ticks, reaching 12 and holding there.
REQ-043 In PLAY, hit_start and game_over in the same frame -> IDLE at the next tick, enabled=0, pspeed=2.
REQ-044 In PLAY with pspeed=5, hit_start, 10 frames, then hit_start -> pspeed stays 5 while paused; the ramp resumes from the frozen count; reset_n pulse mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: drum-hit paddle commands, IDLE/PLAY/PAUSE game state and puck speed ramp,
// all updated once per frame at the vsync falling edge.
module paddle_ctrl #(
    parameter int HOLD_FRAMES = 8,
    parameter int SPEED_MIN   = 2,
    parameter int SPEED_MAX   = 12,
    parameter int RAMP_FRAMES = 600
) (
    input  logic       vclock,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       hit_up,
    input  logic       hit_down,
    input  logic       hit_start,
    input  logic       game_over,
    output logic       up,
    output logic       down,
    output logic [3:0] pspeed,
    output logic       enabled,
    output logic       frame_tick
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int RW = ($clog2(RAMP_FRAMES) > 16) ? $clog2(RAMP_FRAMES) : 16;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [HW-1:0] HOLD_LD   = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_FRAMES - 1);
    localparam logic [3:0] SMIN = 4'(SPEED_MIN);
    localparam logic [3:0] SMAX = 4'(SPEED_MAX);

    logic          vsync_q, armed_q, armed_d;
    logic          pu_q, pd_q, ps_q, pg_q, pu_d, pd_d, ps_d, pg_d;
    logic          up_q, dn_q, up_d, dn_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    state_q, state_d;
    logic [RW-1:0] ramp_q, ramp_d;
    logic [3:0]    speed_q, speed_d;
    logic          tick, ramp_wrap;

    // armed_q blocks a spurious tick from the reset value of vsync_q
    always_comb begin
        tick      = armed_q & vsync_q & ~vsync;
        armed_d   = armed_q | vsync;
        pu_d      = hit_up    | (pu_q & ~tick);
        pd_d      = hit_down  | (pd_q & ~tick);
        ps_d      = hit_start | (ps_q & ~tick);
        pg_d      = game_over | (pg_q & ~tick);
        up_d      = !tick ? up_q : (pu_q | pd_q) ? (pu_q & ~pd_q) : (up_q & (hold_q != HOLD_ONE));
        dn_d      = !tick ? dn_q : (pu_q | pd_q) ? (pd_q & ~pu_q) : (dn_q & (hold_q != HOLD_ONE));
        hold_d    = !tick ? hold_q : (pu_q | pd_q) ? ((pu_q ^ pd_q) ? HOLD_LD : '0) :
                    (hold_q != '0) ? hold_q - 1'b1 : hold_q;
        state_d   = !tick ? state_q : pg_q ? S_IDLE :
                    ps_q ? ((state_q == S_PLAY) ? S_PAUSE : S_PLAY) : state_q;
        ramp_wrap = ramp_q == RAMP_LAST;
        ramp_d    = !tick ? ramp_q : (state_d == S_IDLE) ? '0 :
                    (state_q == S_PLAY) ? (ramp_wrap ? '0 : ramp_q + 1'b1) : ramp_q;
        speed_d   = !tick ? speed_q : (state_d == S_IDLE) ? SMIN :
                    (state_q == S_PLAY && ramp_wrap && speed_q < SMAX) ? speed_q + 1'b1 : speed_q;
    end

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b1;
            armed_q <= 1'b0;
            pu_q    <= 1'b0;
            pd_q    <= 1'b0;
            ps_q    <= 1'b0;
            pg_q    <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            hold_q  <= '0;
            state_q <= S_IDLE;
            ramp_q  <= '0;
            speed_q <= SMIN;
        end else begin
            vsync_q <= vsync;
            armed_q <= armed_d;
            pu_q    <= pu_d;
            pd_q    <= pd_d;
            ps_q    <= ps_d;
            pg_q    <= pg_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            hold_q  <= hold_d;
            state_q <= state_d;
            ramp_q  <= ramp_d;
            speed_q <= speed_d;
        end
    end

    assign up         = up_q;
    assign down       = dn_q;
    assign pspeed     = speed_q;
    assign enabled    = state_q == S_PLAY;
    assign frame_tick = tick;
endmodule
